uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo_mem.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice: serializer state
// encoding, line levels and the bit-period helper.
// Contents:
//   tx_state_t       - serializer FSM states (3-bit encoding)
//   IDLE_LEVEL etc.  - line levels for idle, start and stop bits
//   DATA_BITS        - data bits per frame
//   calc_clks_per_bit- clock cycles per serial bit (integer truncation)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam int   DATA_BITS   = 8;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_mem
// Byte FIFO with synchronous write and combinational read. Pointers carry
// one extra wrap bit so full and empty can be told apart without a counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data this edge (ignored when full)
//   push_data   - byte to store
//   pop         - advance read pointer this edge (ignored when empty)
//   pop_data    - byte at the head of the FIFO
//   full, empty - occupancy flags from registered pointers
//   level       - number of bytes held
// ---------------------------------------------------------------------------
module uart_tx_fifo_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; both may move in the same cycle, leaving level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage has no reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: bytes enter a FIFO over valid/ready and are
// serialized LSB first as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
// Consecutive frames are sent with no idle gap between stop and start.
// Build option:
//   UART_TX_PARITY_EN - insert an even parity bit between data and stop
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   tx_data     - byte offered by upstream
//   tx_valid    - tx_data is valid
//   tx_ready    - FIFO has room (registered state only)
//   uart_tx     - registered serial line, idle high
//   tx_busy     - frame in progress or FIFO non-empty
//   fifo_level  - bytes held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t         state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_cnt, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              line_next;
    logic              baud_done;
    logic              push;
    logic              pop;
    logic [7:0]        pop_data;
    logic              full;
    logic              empty;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit, parity_next;
`endif

    assign tx_ready = !full;
    assign push     = tx_valid && tx_ready;
    assign tx_busy  = (state != IDLE) || !empty;

    uart_tx_fifo_mem #(
        .DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // Serializer state, baud timing and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // Line is registered from the current state, so it trails the FSM by one
    // cycle; every bit still lasts exactly CLKS_PER_BIT cycles on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uart_tx <= IDLE_LEVEL;
        else        uart_tx <= line_next;
    end

    // Next-state logic. Pops happen from IDLE and on the last STOP cycle,
    // the latter giving back-to-back frames without an idle bit.
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt + BAUD_W'(1);
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        pop         = 1'b0;
        line_next   = IDLE_LEVEL;
        baud_done   = (baud_cnt == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                baud_next = '0;
                line_next = IDLE_LEVEL;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = pop_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^pop_data;
`endif
                    state_next = START;
                end
            end
            START: begin
                line_next = START_LEVEL;
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                line_next = shift_reg[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_next = parity_bit;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                line_next = STOP_LEVEL;
                if (baud_done) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = pop_data;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^pop_data;
`endif
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo, built with a short bit period
// (CLK_FREQ=1050, BAUD_RATE=100 -> 10 clocks per bit) so long bursts stay
// short. Honours UART_TX_PARITY_EN when decoding frames.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic [4:0] fifo_level;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg [0:31];

    uart_tx_fifo #(
        .CLK_FREQ   (1050),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        tx_valid = valid;
        tx_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Count cycles until the line goes low, giving up after limit cycles.
    task automatic waitStart(input int limit, output int waited);
        waited = 0;
        while (uart_tx !== 1'b0 && waited < limit) begin
            tick(1);
            waited++;
        end
    endtask

    // Called on the first low sample of a start bit; samples mid-bit and
    // returns on the mid-stop sample.
    task automatic sampleFrame(output logic [7:0] data);
        data = '0;
        tick(CPB / 2);
        checkOutput("start_bit", uart_tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(CPB);
            data[k] = uart_tx;
        end
`ifdef UART_TX_PARITY_EN
        tick(CPB);
        checkOutput("parity_bit", uart_tx, ^data);
`endif
        tick(CPB);
        checkOutput("stop_bit", uart_tx, 1'b1);
    endtask

    // Upstream model: hold valid, advance only when ready was seen high.
    task automatic feedBytes(input int n, input bit checkFull);
        int         idx = 0;
        int         budget = 0;
        logic       readySeen;
        logic [4:0] prevLevel = '0;
        bit         sawFull = 1'b0;
        bit         sawReturn = 1'b0;
        while (idx < n && budget < n * 12 * CPB + 200) begin
            applyStimulus(1'b1, msg[idx]);
            readySeen = tx_ready;
            tick(1);
            budget++;
            if (readySeen) idx++;
            if (checkFull) begin
                if (!tx_ready && !sawFull) begin
                    sawFull = 1'b1;
                    checkOutput("accepted_before_full", idx, 17);
                    checkOutput("level_full", fifo_level, 16);
                end else if (tx_ready && sawFull && !sawReturn) begin
                    sawReturn = 1'b1;
                    checkOutput("level_before_pop", prevLevel, 16);
                    checkOutput("level_after_pop", fifo_level, 15);
                    checkOutput("no_push_while_full", idx, 17);
                end
            end
            prevLevel = fifo_level;
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("feed_done", idx, n);
        if (checkFull) checkOutput("ready_returned", sawReturn, 1'b1);
    endtask

    // Receive n frames, requiring each to follow the previous stop directly.
    task automatic decodeFrames(input int n);
        int         waited;
        logic [7:0] data;
        for (int f = 0; f < n; f++) begin
            if (f == 0) begin
                waitStart(50, waited);
                checkOutput("first_start_seen", waited < 50, 1'b1);
            end else begin
                waitStart(20 * CPB, waited);
                checkOutput("frame_gap", waited, CPB / 2);
            end
            sampleFrame(data);
            checkOutput("frame_data", data, msg[f]);
        end
        tick(3);
        checkOutput("busy_last_stop", tx_busy, 1'b1);
        tick(1);
        checkOutput("busy_dropped", tx_busy, 1'b0);
    endtask

    initial begin
        int         waited;
        logic [7:0] data;
        string      hello;

        // Reset state
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkOutput("reset_uart_tx", uart_tx, 1'b1);
        checkOutput("reset_tx_ready", tx_ready, 1'b1);
        checkOutput("reset_tx_busy", tx_busy, 1'b0);
        checkOutput("reset_level", fifo_level, 0);

        // Single byte 0x55 with exact latency
        applyStimulus(1'b1, 8'h55);
        tick(1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single_level_after_push", fifo_level, 1);
        checkOutput("single_busy", tx_busy, 1'b1);
        tick(1);
        checkOutput("single_level_after_pop", fifo_level, 0);
        checkOutput("single_line_still_idle", uart_tx, 1'b1);
        waitStart(10, waited);
        checkOutput("single_start_latency", waited, 1);
        sampleFrame(data);
        checkOutput("single_data", data, 8'h55);
        tick(3);
        checkOutput("single_busy_stop", tx_busy, 1'b1);
        tick(1);
        checkOutput("single_busy_done", tx_busy, 1'b0);
        tick(CPB);
        checkOutput("single_line_idle", uart_tx, 1'b1);

        // Burst 0x00..0x13 with full-boundary behaviour
        $display("[TB] burst of 20 bytes");
        for (int i = 0; i < 20; i++) msg[i] = 8'(i);
        fork
            feedBytes(20, 1'b1);
            decodeFrames(20);
        join
        tick(CPB);

        // String traffic
        $display("[TB] string traffic");
        hello = "Hello Wolrd!\n";
        for (int i = 0; i < hello.len(); i++) msg[i] = hello[i];
        fork
            feedBytes(hello.len(), 1'b0);
            decodeFrames(hello.len());
        join
        tick(CPB);

        // Reset during DATA bit 3 with 5 bytes queued
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h00);
            tick(1);
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("queued_before_reset", fifo_level, 5);
        tick(42);
        checkOutput("line_low_bit3", uart_tx, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_line", uart_tx, 1'b1);
        checkOutput("async_reset_level", fifo_level, 0);
        checkOutput("async_reset_ready", tx_ready, 1'b1);
        checkOutput("async_reset_busy", tx_busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        waitStart(30 * CPB, waited);
        checkOutput("nothing_after_reset", waited, 30 * CPB);
        checkOutput("level_after_release", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
